// File: rtl/gaussian_filter_nxn.sv
// Streaming 3x3 / 5x5 Gaussian filter over a 5x5 window fed by 4 line buffers.
// Define GAUSS_BORDER_BYPASS_EN to pass frame-edge pixels through unfiltered.
module gaussian_filter_nxn #(
  parameter int BITS   = 8,
  parameter int WIDTH  = 1936,
  parameter int HEIGHT = 1096
) (
  input  logic            pclk,
  input  logic            rst,
  input  logic            per_frame_vsync,
  input  logic [1:0]      mode,
  input  logic [BITS-1:0] per_raw_data,
  input  logic            per_raw_clken,
  output logic [BITS-1:0] post_raw_data,
  output logic            post_raw_clken,
  output logic            post_border
);
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam int PW = BITS + 6;
  localparam int SW = BITS + 11;

  localparam logic [5:0] G5 [5][5] = '{
    '{6'd32, 6'd38, 6'd40, 6'd38, 6'd32},
    '{6'd38, 6'd45, 6'd47, 6'd45, 6'd38},
    '{6'd40, 6'd47, 6'd50, 6'd47, 6'd40},
    '{6'd38, 6'd45, 6'd47, 6'd45, 6'd38},
    '{6'd32, 6'd38, 6'd40, 6'd38, 6'd32}
  };
  localparam logic [5:0] G3 [5][5] = '{
    '{6'd0, 6'd0, 6'd0, 6'd0, 6'd0},
    '{6'd0, 6'd1, 6'd2, 6'd1, 6'd0},
    '{6'd0, 6'd2, 6'd4, 6'd2, 6'd0},
    '{6'd0, 6'd1, 6'd2, 6'd1, 6'd0},
    '{6'd0, 6'd0, 6'd0, 6'd0, 6'd0}
  };

  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [1:0]      mode_q, mode_d;
  logic [BITS-1:0] lb_q [4][WIDTH];
  logic [BITS-1:0] colv [5];
  logic [BITS-1:0] win_q [5][5];
  logic [3:0]      v_q;
  logic [1:0]      sel_q [4];
  logic [3:0]      bd_q;
  logic [1:0]      sel_d;
  logic            bd_d;
  logic [5:0]      w_c [5][5];
  logic [PW-1:0]   prod_q [5][5];
  logic [SW-1:0]   rs_d [5];
  logic [SW-1:0]   rs_q [5];
  logic [SW-1:0]   tot_d, tot_q, res;
  logic [BITS-1:0] sat;
  logic [BITS-1:0] data_q;
  logic            vld_q, brd_q;

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    mode_d = mode_q;
    if (per_frame_vsync) begin
      col_d  = '0;
      row_d  = '0;
      mode_d = mode;
    end else if (per_raw_clken) begin
      if (col_q == CW'(WIDTH - 1)) begin
        col_d = '0;
        if (row_q != RW'(HEIGHT - 1)) row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      mode_q <= 2'd2;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      mode_q <= mode_d;
    end
  end

  // colv[0] is the oldest line (four rows up), colv[4] the live pixel
  always_comb begin
    for (int i = 0; i < 4; i++) colv[i] = lb_q[3-i][col_q];
    colv[4] = per_raw_data;
  end

  always_ff @(posedge pclk) begin
    if (per_raw_clken) begin
      lb_q[0][col_q] <= per_raw_data;
      for (int i = 1; i < 4; i++) lb_q[i][col_q] <= lb_q[i-1][col_q];
      for (int i = 0; i < 5; i++) begin
        for (int j = 0; j < 4; j++) win_q[i][j] <= win_q[i][j+1];
        win_q[i][4] <= colv[i];
      end
    end
  end

`ifdef GAUSS_BORDER_BYPASS_EN
  logic          brw;
  logic [CW-1:0] cen_c;
  logic [RW-1:0] rsub, cen_r;

  // centre sits 2 rows and 2 columns behind the counters, frame-wrapped
  always_comb begin
    brw   = col_q < CW'(2);
    cen_c = brw ? col_q + CW'(WIDTH - 2) : col_q - CW'(2);
    rsub  = RW'(2) + RW'(brw);
    cen_r = (row_q >= rsub) ? row_q - rsub
                            : row_q + RW'(HEIGHT) - rsub;
    sel_d = (mode_q == 2'd3) ? 2'd2 : mode_q;
    bd_d  = 1'b0;
    unique case (1'b1)
      sel_d == 2'd2:
        bd_d = cen_r < RW'(2) || cen_r > RW'(HEIGHT - 3) ||
               cen_c < CW'(2) || cen_c > CW'(WIDTH - 3);
      sel_d == 2'd1:
        bd_d = cen_r < RW'(1) || cen_r > RW'(HEIGHT - 2) ||
               cen_c < CW'(1) || cen_c > CW'(WIDTH - 2);
      default: bd_d = 1'b0;
    endcase
    if (bd_d) sel_d = 2'd0;
  end
`else
  always_comb begin
    sel_d = (mode_q == 2'd3) ? 2'd2 : mode_q;
    bd_d  = 1'b0;
  end
`endif

  always_ff @(posedge pclk) begin
    if (rst) begin
      v_q <= '0;
    end else begin
      v_q <= {v_q[2:0], per_raw_clken};
    end
  end

  always_ff @(posedge pclk) begin
    if (per_raw_clken) begin
      sel_q[0] <= sel_d;
      bd_q[0]  <= bd_d;
    end
    for (int i = 1; i < 4; i++) begin
      if (v_q[i-1]) begin
        sel_q[i] <= sel_q[i-1];
        bd_q[i]  <= bd_q[i-1];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        unique case (sel_q[0])
          2'd2:    w_c[i][j] = G5[i][j];
          2'd1:    w_c[i][j] = G3[i][j];
          default: w_c[i][j] = (i == 2 && j == 2) ? 6'd1 : 6'd0;
        endcase
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      rs_d[i] = '0;
      for (int j = 0; j < 5; j++) rs_d[i] = rs_d[i] + SW'(prod_q[i][j]);
    end
    tot_d = '0;
    for (int i = 0; i < 5; i++) tot_d = tot_d + rs_q[i];
  end

  always_ff @(posedge pclk) begin
    if (v_q[0]) begin
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 5; j++)
          prod_q[i][j] <= PW'(win_q[i][j]) * PW'(w_c[i][j]);
    end
    if (v_q[1]) rs_q <= rs_d;
    if (v_q[2]) tot_q <= tot_d;
  end

  always_comb begin
    unique case (sel_q[3])
      2'd2:    res = (tot_q + SW'(512)) >> 10;
      2'd1:    res = (tot_q + SW'(8)) >> 4;
      default: res = tot_q;
    endcase
    sat = (res > SW'(2**BITS - 1)) ? '1 : res[BITS-1:0];
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      data_q <= '0;
      vld_q  <= 1'b0;
      brd_q  <= 1'b0;
    end else begin
      vld_q <= v_q[3];
      if (v_q[3]) begin
        data_q <= sat;
        brd_q  <= bd_q[3];
      end
    end
  end

  assign post_raw_data  = data_q;
  assign post_raw_clken = vld_q;
  assign post_border    = brd_q;

endmodule

// File: tb/tb_gaussian_filter_nxn.sv
// Randomised scoreboard bench for gaussian_filter_nxn (8x6 frame, 8-bit).
// Follows GAUSS_BORDER_BYPASS_EN the same way the design does.
module tb_gaussian_filter_nxn;
  localparam int BITS = 8;
  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            vs = 1'b0;
  logic [1:0]      mode = 2'd2;
  logic [BITS-1:0] din = '0;
  logic            clken = 1'b0;
  logic [BITS-1:0] dout;
  logic            dvld;
  logic            dbrd;

  gaussian_filter_nxn #(.BITS(BITS), .WIDTH(W), .HEIGHT(H)) dut (
    .pclk(clk),
    .rst(rst),
    .per_frame_vsync(vs),
    .mode(mode),
    .per_raw_data(din),
    .per_raw_clken(clken),
    .post_raw_data(dout),
    .post_raw_clken(dvld),
    .post_border(dbrd)
  );

  always #5 clk = ~clk;

  typedef struct {
    int val;
    bit bd;
    bit known;
    int cyc;
    int r;
    int c;
  } exp_t;

  int G5 [5][5] = '{
    '{32, 38, 40, 38, 32},
    '{38, 45, 47, 45, 38},
    '{40, 47, 50, 47, 40},
    '{38, 45, 47, 45, 38},
    '{32, 38, 40, 38, 32}
  };

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  exp_t me;
  int   hist[$];
  int   mr = 0, mc = 0, mode_l = 2;
  int   last_val = 0;
  bit   last_known = 1'b1;
  int   cap_v [H][W];
  bit   cap_b [H][W];
  int   rec_sel = 0;
  int   recA[$], recB[$];
  int   pat [N];

  always @(posedge clk) cyc <= cyc + 1;

  // expected output for the strobe whose pixel sits at hist[k]
  function automatic exp_t predict(input int k);
    exp_t e;
    int lin, m, s, idx, wt;
    bit bord;
    lin = (mr * W + mc - 2 * W - 2 + N) % N;
    e.r = lin / W;
    e.c = lin % W;
    e.cyc = cyc + 5;
    e.known = 1'b1;
    e.val = 0;
    m = (mode_l == 3) ? 2 : mode_l;
    bord = 1'b0;
`ifdef GAUSS_BORDER_BYPASS_EN
    if (m == 2)
      bord = e.r < 2 || e.r > H - 3 || e.c < 2 || e.c > W - 3;
    else if (m == 1)
      bord = e.r < 1 || e.r > H - 2 || e.c < 1 || e.c > W - 2;
`endif
    e.bd = bord;
    if (m == 0 || bord) begin
      idx = k - 2 * W - 2;
      e.known = idx >= 0;
      if (e.known) e.val = hist[idx];
    end else begin
      s = 0;
      for (int dr = -2; dr <= 2; dr++) begin
        for (int dc = -2; dc <= 2; dc++) begin
          if (m == 2) wt = G5[dr+2][dc+2];
          else if (dr >= -1 && dr <= 1 && dc >= -1 && dc <= 1)
            wt = (dr == 0 ? 2 : 1) * (dc == 0 ? 2 : 1);
          else wt = 0;
          if (wt != 0) begin
            idx = k - (2 - dr) * W - (2 - dc);
            if (idx < 0) e.known = 1'b0;
            else s += wt * hist[idx];
          end
        end
      end
      e.val = (m == 2) ? (s + 512) >> 10 : (s + 8) >> 4;
      if (e.val > 2**BITS - 1) e.val = 2**BITS - 1;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_out: none at cycle %0d, required one",
                 exp_q[0].cyc);
        me = exp_q.pop_front();
      end
      if (dvld) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_out: clken=1 at cycle %0d, required 0",
                   cyc);
        end else begin
          me = exp_q.pop_front();
          if (me.cyc != cyc) begin
            errors++;
            $display("FAIL latency: out at cycle %0d, required %0d",
                     cyc, me.cyc);
          end
          if (me.known) begin
            checks++;
            if (dout != BITS'(me.val) || dbrd != me.bd) begin
              errors++;
              $display("FAIL pix(%0d,%0d): got %0d/b%0d, required %0d/b%0d",
                       me.r, me.c, dout, dbrd, me.val, me.bd);
            end
          end
          cap_v[me.r][me.c] = int'(dout);
          cap_b[me.r][me.c] = dbrd;
          if (rec_sel == 1) recA.push_back(int'(dout));
          if (rec_sel == 2) recB.push_back(int'(dout));
          last_val = me.val;
          last_known = me.known;
        end
      end else if (last_known) begin
        checks++;
        if (dout != BITS'(last_val)) begin
          errors++;
          $display("FAIL hold: data %0d while idle, required %0d",
                   dout, last_val);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic vsync();
    vs = 1'b1;
    mode_l = int'(mode);
    mr = 0;
    mc = 0;
    idle(1);
    vs = 1'b0;
  endtask

  task automatic strobe(input int pix);
    hist.push_back(pix);
    exp_q.push_back(predict(hist.size() - 1));
    din = BITS'(pix);
    clken = 1'b1;
    idle(1);
    clken = 1'b0;
    mc++;
    if (mc == W) begin
      mc = 0;
      if (mr < H - 1) mr++;
    end
  endtask

  task automatic frame(input int gmax, input bit chg);
    for (int i = 0; i < N; i++) begin
      if (chg && i == N / 2) mode = 2'($urandom_range(0, 3));
      strobe(pat[i]);
      if (gmax > 0) idle($urandom_range(0, gmax));
    end
    idle(8);
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < N; i++) pat[i] = v;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < N; i++) pat[i] = $urandom_range(0, 255);
  endtask

  initial begin
    idle(3);
    chk("rst_data", int'(dout), 0);
    chk("rst_clken", int'(dvld), 0);
    chk("rst_border", int'(dbrd), 0);
    rst = 1'b0;

    mode = 2'd2;
    fill(100);
    vsync();
    frame(0, 1'b0);
    chk("flat5_int23", cap_v[2][3], 99);
    chk("flat5_int32", cap_v[3][2], 99);
    chk("flat5_int_b", int'(cap_b[2][3]), 0);
`ifdef GAUSS_BORDER_BYPASS_EN
    chk("flat5_bord00", cap_v[0][0], 100);
    chk("flat5_bord00_b", int'(cap_b[0][0]), 1);
    chk("flat5_bord14", cap_v[1][4], 100);
    chk("flat5_bord14_b", int'(cap_b[1][4]), 1);
`else
    chk("flat5_bord_b", int'(cap_b[0][0]), 0);
`endif

    mode = 2'd1;
    vsync();
    frame(0, 1'b0);
    chk("flat3_22", cap_v[2][2], 100);
    chk("flat3_11", cap_v[1][1], 100);
    chk("flat3_03", cap_v[0][3], 100);

    mode = 2'd0;
    vsync();
    frame(0, 1'b0);
    chk("flatbp_25", cap_v[2][5], 100);
    chk("flatbp_25_b", int'(cap_b[2][5]), 0);
    chk("flatbp_01", cap_v[0][1], 100);

    mode = 2'd2;
    fill(0);
    pat[3 * W + 3] = 255;
    vsync();
    frame(0, 1'b0);
    chk("imp_33", cap_v[3][3], 12);
    chk("imp_34", cap_v[3][4], 12);
    chk("imp_35", cap_v[3][5], 10);
    chk("imp_22", cap_v[2][2], 11);

    fill_rand();
    vsync();
    frame(0, 1'b0);
    vsync();
    rec_sel = 1;
    frame(0, 1'b0);
    rec_sel = 0;
    vsync();
    frame(3, 1'b0);
    vsync();
    rec_sel = 2;
    frame(3, 1'b0);
    rec_sel = 0;
    chk("gap_count", recB.size(), recA.size());
    for (int i = 0; i < recA.size() && i < recB.size(); i++)
      chk($sformatf("gap_seq%0d", i), recB[i], recA[i]);

    mode = 2'd2;
    fill(100);
    vsync();
    for (int i = 0; i < N; i++) begin
      if (i == 3 * W) mode = 2'd0;
      strobe(100);
    end
    idle(8);
    chk("msw_33", cap_v[3][3], 99);
    chk("msw_34", cap_v[3][4], 99);
    vsync();
    frame(0, 1'b0);
    chk("msw_next22", cap_v[2][2], 100);
    chk("msw_next22_b", int'(cap_b[2][2]), 0);

    for (int f = 0; f < 4; f++) begin
      mode = 2'($urandom_range(0, 3));
      fill_rand();
      vsync();
      frame(2, 1'b1);
    end

    mode = 2'd1;
    fill_rand();
    vsync();
    for (int i = 0; i < W + 3; i++) strobe(pat[i]);
    rst = 1'b1;
    idle(1);
    chk("mid_rst_data", int'(dout), 0);
    chk("mid_rst_clken", int'(dvld), 0);
    chk("mid_rst_border", int'(dbrd), 0);
    rst = 1'b0;
    exp_q.delete();
    hist.delete();
    mr = 0;
    mc = 0;
    mode_l = 2;
    last_val = 0;
    last_known = 1'b1;
    idle(3);
    fill_rand();
    frame(0, 1'b0);
    mode = 2'd1;
    vsync();
    frame(2, 1'b0);
    mode = 2'd2;
    vsync();
    frame(1, 1'b0);

    idle(10);
    chk("drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gaussian_filter_nxn.md
GAUSSIAN_FILTER_NXN -- requirements
Module: gaussian_filter_nxn

Interface
REQ-001 Parameter BITS, default 8: pixel width; legal range 8..12.
REQ-002 Parameter WIDTH, default 1936: active pixels per line.
REQ-003 Parameter HEIGHT, default 1096: active lines per frame.
REQ-004 pclk  input  1  pixel clock; the block uses this clock only.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 per_frame_vsync  input  1  one-cycle pulse before the first pixel of a frame.
REQ-007 mode  input  2  filter mode: 0 bypass, 1 3x3, 2 5x5, 3 same as 2.
REQ-008 per_raw_data  input  BITS  input pixel; valid when per_raw_clken=1.
REQ-009 per_raw_clken  input  1  input pixel strobe; gaps of any length allowed.
REQ-010 post_raw_data  output  BITS  filtered pixel.
REQ-011 post_raw_clken  output  1  output pixel strobe.
REQ-012 post_border  output  1  the current output pixel is a border pass-through.

Function
REQ-013 Four BITS-wide line buffers of depth WIDTH and the 5x5 window shall advance only on per_raw_clken=1; idle cycles shall leave all window and line state unchanged.
REQ-014 A column counter shall count 0..WIDTH-1 on each strobe and wrap to 0; a row counter shall increment on each column wrap and saturate at HEIGHT-1; per_frame_vsync shall clear both counters.
REQ-015 mode shall be sampled only on per_frame_vsync; a mid-frame change of mode shall take effect at the next frame.
REQ-016 Each output pixel shall be centred on the input received 2*WIDTH+2 strobes earlier; the centre coordinates are the counters minus (2,2), taken modulo frame size.
REQ-017 Mode 5x5 weights shall be rows [32 38 40 38 32] [38 45 47 45 38] [40 47 50 47 40] [38 45 47 45 38] [32 38 40 38 32]; result = (sum + 512) >> 10.
REQ-018 Mode 3x3 shall use the inner 3x3 window with weights [1 2 1; 2 4 2; 1 2 1]; result = (sum + 8) >> 4.
REQ-019 Bypass mode shall output the centre pixel unchanged.
REQ-020 Every result shall saturate to 2^BITS-1; internal sums shall be wide enough never to overflow for any BITS.
REQ-021 The pipeline after the window shall be four registered stages: multiply, row sum, total, round/saturate.
REQ-022 post_raw_clken shall assert exactly 5 cycles after the cycle in which per_raw_clken=1, in every mode, so latency is mode-independent.
REQ-023 The pipeline shall accept one strobe per cycle with no backpressure.
REQ-024 post_raw_data shall hold its last value while post_raw_clken=0.

Reset
REQ-025 While rst=1: post_raw_data=0, post_raw_clken=0, post_border=0, counters=0, pipeline valids=0, latched mode=2.
REQ-026 Line-buffer contents need not be cleared by reset.
REQ-027 If reset is asserted mid-frame, post_raw_clken shall be 0 from the cycle after the first rst=1 edge until new strobes propagate after reset is released.

Configuration
REQ-028 GAUSS_BORDER_BYPASS_EN defined: when the centre lies within 2 (5x5) or 1 (3x3) pixels of any frame edge, the block shall output the centre pixel unfiltered and set post_border=1.
REQ-029 GAUSS_BORDER_BYPASS_EN undefined: the block shall filter every pixel using whatever data the window holds, and post_border shall be tied to 0.

Verification
Bench parameters for all scenarios: BITS=8, WIDTH=8, HEIGHT=6, GAUSS_BORDER_BYPASS_EN defined.
REQ-030 Flat frame of 100, mode 5x5 -> interior outputs 99, border outputs 100 with post_border=1.
REQ-031 Flat frame of 100, modes 3x3 and bypass -> every output is 100.
REQ-032 Single 255 impulse at (row 3, col 3) on a 0 background, mode 5x5 -> output 12 at the centre, 12 at (3,4), 10 at (3,5).
REQ-033 A strobe at cycle t -> post_raw_clken at t+5; run random clken gaps -> output sequence identical to a gapless run.
REQ-034 Switch mode from 2 to 0 mid-frame -> outputs stay filtered until the next vsync, then become bypass.
REQ-035 Assert rst for 1 cycle mid-line -> all outputs 0 on the next cycle; after release, the first post_raw_clken appears 5 cycles after the first new strobe.
